egress_arbiter: RTL and testbench
=================================

# egress_arbiter

Downstream stage of the classifier/router + dual-FIFO pipeline (`device3`): drains the two 8-bit FIFO outputs through a round-robin arbiter and delivers one tagged 10-bit word at a time on a valid/ready egress port. Each word carries source lane, even-parity bit and payload. The block also keeps saturating per-lane forward counters and an error-event counter fed by the upstream classify/route error flags.

## Interface
- `DATA_SIZE`, 10, egress word width; must equal `MAIN_SIZE + 2`
- `MAIN_SIZE`, 8, FIFO payload width
- `CNT_WIDTH`, 8, width of every statistics counter
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `data0` / `data1`  in  MAIN_SIZE  FIFO 0/1 read data; valid the cycle after the matching pop
- `empty0` / `empty1`  in  1  FIFO 0/1 empty flag
- `error0` / `error1`  in  1  upstream classify/route error level
- `out_ready`  in  1  egress consumer accepts a word this cycle
- `pop0` / `pop1`  out  1  one-cycle read strobe to FIFO 0/1
- `out_data`  out  DATA_SIZE  {lane[9], parity[8], payload[7:0]}
- `out_valid`  out  1  `out_data` valid; held until accepted
- `count0` / `count1`  out  CNT_WIDTH  words forwarded from lane 0/1, saturating
- `err_count`  out  CNT_WIDTH  error rising edges seen, saturating
- `idle`  out  1  high in IDLE state

## Operation
- FSM states: IDLE, ISSUE, WAIT, SEND.
- IDLE: if any `emptyK` is low, grant and go to ISSUE; otherwise stay.
- ISSUE: `popK` is high for the granted lane for exactly this cycle. Next state is WAIT.
- WAIT: FIFO data is valid. On the edge leaving WAIT, register `out_data = {grant, ^dataK, dataK}`. Next state is SEND.
- SEND: `out_valid` = 1 and `out_data` is stable.
  - Handshake when `out_valid && out_ready`.
  - On handshake with a lane non-empty: grant and go to ISSUE.
  - On handshake with both lanes empty: go to IDLE.
  - Without handshake: stay in SEND.
- Grant rule:
  - Only one lane non-empty: that lane wins.
  - Both lanes non-empty: the lane other than `last_grant` wins.
  - `last_grant` updates on every grant; its reset value is 1, so lane 0 wins the first contention.
- Pops occur only for a lane sampled non-empty at the grant cycle. This block is the sole reader, so the FIFO cannot drain in between.
- `countK` increments on a handshake of a lane-K word and holds at all-ones.
- Error edge detection:
  - Registered `error0_q` / `error1_q`.
  - Each cycle, `err_count` adds the number of rising edges, 0, 1 or 2.
  - The result saturates at all-ones; all-ones minus 1 plus 2 gives all-ones.
- Parity bit = XOR of the 8 payload bits, so the 9-bit {parity, payload} has even parity.

## Timing
- Reset values: state IDLE, `pop0`/`pop1`/`out_valid` = 0, `out_data` = 0, all counters = 0, `error*_q` = 0, `last_grant` = 1, `idle` = 1.
- Latency: `emptyK` sampled low at edge T means `popK` is high in cycle T+1 and `out_valid` is high from cycle T+3.
- Back-to-back throughput: one word per 3 cycles (SEND→ISSUE→WAIT→SEND) with `out_ready` held high.
- `out_valid` never drops and `out_data` never changes before a handshake.
- `pop0` and `pop1` are never high together and never high outside ISSUE.
- Reset asserted mid-transfer, in ISSUE/WAIT/SEND, drops the in-flight word. The word has already left the FIFO, and this loss is accepted behaviour.
- A handshake and an error edge in the same cycle update both counters independently.

## Structure
- Shared header `egress_defs`: state encodings, `LANE_BIT` = 9, `PAR_BIT` = 8, payload slice constants.
- One sub-module `sat_counter`: parameterised width, increment amount input of 0–2, saturating. It is instantiated three times: `count0`, `count1`, `err_count`.
- The FSM, grant logic and output register stay in `egress_arbiter`.

## Test plan
- Reset, then `empty1`=1 and `empty0` low with `data0`=8'hA5 → `pop0` high in cycle 2 and `out_data`=10'b0_0_10100101 valid in cycle 4; with `out_ready`=1, `count0`=1.
- Both lanes non-empty with 3 words each, `out_ready`=1 → grant order 0,1,0,1,0,1, one word per 3 cycles, `count0`=`count1`=3, `idle` high after the last word.
- `out_ready` low for 10 cycles in SEND → `out_valid` and `out_data` held, no further pops; with `data1`=8'h01 the held word is 10'b1_1_00000001.
- `error0` and `error1` rising in the same cycle, 200 times → `err_count` = 8'hFF (saturated), with no wrap to 0.
- Assert `reset` during WAIT → all outputs return to reset values asynchronously; the next transfer restarts with lane 0 priority.

Source files
------------

// File: rtl/egress_arbiter_pkg.sv
// Shared egress definitions: FSM state encoding and egress word field positions.
// No logic; constants only.
// Imported by the arbiter and its counters.
package egress_arbiter_pkg;

    // Egress word layout {lane, parity, payload}
    localparam int LANE_BIT = 9;
    localparam int PAR_BIT  = 8;
    localparam int PAY_MSB  = 7;
    localparam int PAY_LSB  = 0;

    // Counter increment input width (0, 1 or 2 per cycle)
    localparam int INC_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/egress_arbiter_sat_counter.sv
// Saturating statistics counter; adds 0..2 per cycle and sticks at all-ones.
// Latency: count reflects the increment one cycle after it is presented.
// No backpressure; the increment is always consumed.
module sat_counter
    import egress_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH:0] sum;

    // One extra bit catches the carry so overflow clamps instead of wrapping
    always_comb begin
        sum = {1'b0, count} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};
    end

    // Accumulate, clamping at all-ones whenever the sum carries out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (sum[WIDTH]) begin
            count <= '1;
        end else begin
            count <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// Round-robin drain of two FIFOs into one tagged {lane, parity, payload} egress word.
// Latency: empty sampled low at edge T -> pop in T+1 -> out_valid from T+3; 3 cycles/word.
// Backpressure: out_valid/out_data hold until out_ready; no pops issue while a word waits.
module egress_arbiter
    import egress_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MAIN_SIZE-1:0] data0,
    input  logic [MAIN_SIZE-1:0] data1,
    input  logic                 empty0,
    input  logic                 empty1,
    input  logic                 error0,
    input  logic                 error1,
    input  logic                 out_ready,
    output logic                 pop0,
    output logic                 pop1,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 idle
);

    state_t               state;
    logic                 last_grant;
    logic                 grant;
    logic                 error0_q;
    logic                 error1_q;
    logic                 any_ready;
    logic                 pick;
    logic                 handshake;
    logic [MAIN_SIZE-1:0] sel_data;
    logic                 rise0;
    logic                 rise1;
    logic [INC_W-1:0]     inc0;
    logic [INC_W-1:0]     inc1;
    logic [INC_W-1:0]     err_inc;

    // Grant choice: a lone non-empty lane wins; on contention the lane not granted last wins
    always_comb begin
        any_ready = ~empty0 | ~empty1;
        if (~empty0 & ~empty1) begin
            pick = ~last_grant;
        end else begin
            pick = empty0;
        end
        handshake = out_valid & out_ready;
        sel_data  = grant ? data1 : data0;
        rise0     = error0 & ~error0_q;
        rise1     = error1 & ~error1_q;
        inc0      = {1'b0, handshake & ~out_data[LANE_BIT]};
        inc1      = {1'b0, handshake &  out_data[LANE_BIT]};
        err_inc   = {rise0 & rise1, rise0 ^ rise1};
    end

    // Arbiter FSM with registered pop, egress word and idle outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pop0       <= 1'b0;
            pop1       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            idle       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_ready) begin
                        grant      <= pick;
                        last_grant <= pick;
                        pop0       <= ~pick;
                        pop1       <= pick;
                        idle       <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    pop0  <= 1'b0;
                    pop1  <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // FIFO read data is valid now; capture it with its tag and parity
                    out_data[LANE_BIT]        <= grant;
                    out_data[PAR_BIT]         <= ^sel_data;
                    out_data[PAY_MSB:PAY_LSB] <= sel_data;
                    out_valid                 <= 1'b1;
                    state                     <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (any_ready) begin
                            grant      <= pick;
                            last_grant <= pick;
                            pop0       <= ~pick;
                            pop1       <= pick;
                            state      <= ST_ISSUE;
                        end else begin
                            idle  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Error level history for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error0_q <= 1'b0;
            error1_q <= 1'b0;
        end else begin
            error0_q <= error0;
            error1_q <= error1;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_count0 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc0),
        .count (count0)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_count1 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc1),
        .count (count1)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_egress_arbiter.sv
// Bench for egress_arbiter: FIFO model on the inputs, word-order scoreboard on the output.
// Expected words come from a lane-level round-robin plan over the queued payloads.
// Randomized out_ready and error levels; directed latency, hold, saturation and reset cases.
module tb_egress_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data0, data1;
    logic       empty0, empty1, error0, error1, out_ready;
    logic       pop0, pop1, out_valid, idle;
    logic [9:0] out_data;
    logic [7:0] count0, count1, err_count;

    egress_arbiter #(.DATA_SIZE(10), .MAIN_SIZE(8), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .data0     (data0),
        .data1     (data1),
        .empty0    (empty0),
        .empty1    (empty1),
        .error0    (error0),
        .error1    (error1),
        .out_ready (out_ready),
        .pop0      (pop0),
        .pop1      (pop1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count0    (count0),
        .count1    (count1),
        .err_count (err_count),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // FIFO contents still to be read, and expected egress words in order
    byte unsigned q0[$];
    byte unsigned q1[$];
    logic [9:0]   exp_q[$];

    bit         m_last = 1'b1;
    int         m_cnt0 = 0, m_cnt1 = 0, m_err = 0;
    bit         err_prev0 = 1'b0, err_prev1 = 1'b0;
    bit         obs_pop0 = 1'b0, obs_pop1 = 1'b0, obs_valid = 1'b0;
    logic [9:0] obs_data = '0;
    bit         rand_io = 1'b0;
    bit         chk_gap = 1'b0;
    int         cyc = 0;
    int         last_hs = -1;

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    function automatic logic [9:0] word(input bit lane, input logic [7:0] p);
        return {lane, ^p, p};
    endfunction

    // Round-robin order of the queued words, assuming nothing is added while draining
    task automatic plan();
        byte unsigned c0[$];
        byte unsigned c1[$];
        bit lane;
        logic [7:0] p;
        c0 = q0;
        c1 = q1;
        while (c0.size() != 0 || c1.size() != 0) begin
            if (c0.size() != 0 && c1.size() != 0) lane = !m_last;
            else lane = (c0.size() == 0);
            m_last = lane;
            if (lane) p = c1.pop_front();
            else p = c0.pop_front();
            exp_q.push_back(word(lane, p));
        end
    endtask

    task automatic set_empties();
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
    endtask

    // One clock: score the handshake and error edges at the edge, then model the FIFOs
    task automatic tick();
        bit         v, r;
        logic [9:0] d, e;
        int         rises;
        v = obs_valid;
        r = out_ready;
        d = obs_data;
        @(posedge clk);
        cyc++;
        if (v && r) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("word", d, e);
                if (e[9]) m_cnt1 = sat_add(m_cnt1, 1);
                else m_cnt0 = sat_add(m_cnt0, 1);
            end
            if (chk_gap && last_hs >= 0) chk("gap", cyc - last_hs, 3);
            last_hs = cyc;
        end
        rises = int'(error0 && !err_prev0) + int'(error1 && !err_prev1);
        m_err = sat_add(m_err, rises);
        err_prev0 = error0;
        err_prev1 = error1;
        #1;
        if (obs_pop0) begin
            chk("pop0_nonempty", q0.size() != 0, 1);
            if (q0.size() != 0) data0 = q0.pop_front();
        end
        if (obs_pop1) begin
            chk("pop1_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) data1 = q1.pop_front();
        end
        set_empties();
        if (v && !r) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, d);
        end
        if (pop0 || pop1) chk("pop_excl", pop0 & pop1, 0);
        obs_pop0  = pop0;
        obs_pop1  = pop1;
        obs_valid = out_valid;
        obs_data  = out_data;
        if (rand_io) begin
            out_ready = ($urandom_range(0, 9) < 7);
            error0    = $urandom_range(0, 1);
            error1    = $urandom_range(0, 1);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk({tag, "_timeout"}, n, 0);
        chk({tag, "_count0"}, count0, m_cnt0);
        chk({tag, "_count1"}, count1, m_cnt1);
        chk({tag, "_err"}, err_count, m_err);
        chk({tag, "_idle"}, idle, 1);
    endtask

    initial begin
        int n0, n1;
        reset = 1'b1;
        data0 = '0; data1 = '0;
        empty0 = 1'b1; empty1 = 1'b1;
        error0 = 1'b0; error1 = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pops", {pop0, pop1}, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_counts", {count0, count1, err_count}, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b0;

        // Single lane-0 word: pop one cycle after sampling, valid two cycles later
        q0.push_back(8'hA5);
        plan();
        set_empties();
        tick();
        chk("lat_pop0", pop0, 1);
        chk("lat_pop1", pop1, 0);
        tick();
        chk("lat_valid_early", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 10'b0_0_10100101);
        out_ready = 1'b1;
        tick();
        chk("lat_count0", count0, 1);
        chk("lat_idle", idle, 1);
        out_ready = 1'b0;

        // Stalled consumer: word and valid held, no pops for 10 cycles
        q1.push_back(8'h01);
        plan();
        set_empties();
        repeat (3) tick();
        chk("stall_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_nopop", {pop0, pop1}, 0);
        end
        chk("stall_word", out_data, 10'b1_1_00000001);
        out_ready = 1'b1;
        drain("stall");

        // Back-to-back contention, ready held high: alternating lanes, 3 cycles per word
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'($urandom));
            q1.push_back(8'($urandom));
        end
        plan();
        set_empties();
        chk_gap = 1'b1;
        last_hs = -1;
        drain("b2b");
        chk_gap = 1'b0;
        chk("b2b_count0", count0, 4);
        chk("b2b_count1", count1, 4);
        out_ready = 1'b0;

        // Error counter saturation with simultaneous rising edges
        for (int i = 0; i < 200; i++) begin
            error0 = 1'b1; error1 = 1'b1;
            tick();
            error0 = 1'b0; error1 = 1'b0;
            tick();
            if (i == 63) chk("err_mid", err_count, m_err);
        end
        chk("err_sat", err_count, 8'hFF);
        chk("err_model", err_count, m_err);

        // Randomized bursts with random backpressure and error activity
        rand_io = 1'b1;
        for (int p = 0; p < 8; p++) begin
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(0, 5);
            for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
            for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
            plan();
            set_empties();
            drain("rand");
        end
        rand_io = 1'b0;
        error0 = 1'b0; error1 = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset during WAIT: in-flight word lost, restart grants lane 0 first
        q0.push_back(8'h11); q0.push_back(8'h12);
        q1.push_back(8'h21); q1.push_back(8'h22);
        plan();
        set_empties();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("arst_pops", {pop0, pop1}, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_counts", {count0, count1, err_count}, 0);
        chk("arst_idle", idle, 1);
        m_cnt0 = 0; m_cnt1 = 0; m_err = 0;
        m_last = 1'b1;
        err_prev0 = 1'b0; err_prev1 = 1'b0;
        obs_pop0 = 1'b0; obs_pop1 = 1'b0; obs_valid = 1'b0; obs_data = '0;
        exp_q.delete();
        plan();
        #1;
        reset = 1'b0;
        tick();
        chk("arst_lane0_first", {pop0, pop1}, 2'b10);
        out_ready = 1'b1;
        drain("arst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
